// File: rtl/norm_ctrl.sv
// Post-add normalizer: steers the exponent register and shifts the sum mantissa until the hidden bit sits at MANT_W-1.
// Latency is 3 cycles, plus 1 for a carry or fix-up and 2 per left shift; start is ignored while busy, with no other backpressure.
module norm_ctrl #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MANT_W:0]   sum_mant,
  input  logic [EXP_W-1:0]  sum_expo,
  input  logic [EXP_W-1:0]  expo_val,
  output logic              ldex,
  output logic              ince,
  output logic              dece,
  output logic [EXP_W-1:0]  ld_expo,
  output logic [MANT_W-1:0] norm_mant,
  output logic              busy,
  output logic              done,
  output logic              zero,
  output logic              ovf,
  output logic              unf
);

  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_SAT = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_SHR, S_SHL, S_FIX, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [MANT_W:0]   mreg_q, mreg_d;
  logic [EXP_W-1:0]  ld_expo_q, ld_expo_d;
  logic              ldex_q, ldex_d, ince_q, ince_d, dece_q, dece_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;

  // Outputs are registered alongside the state they belong to, so each command
  // is visible in the same cycle the FSM sits in its issuing state.
  always_comb begin
    state_d   = state_q;
    mreg_d    = mreg_q;
    ld_expo_d = ld_expo_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          mreg_d    = sum_mant;
          ld_expo_d = sum_expo;
          zero_d    = 1'b0;
          ovf_d     = 1'b0;
          unf_d     = 1'b0;
        end
      end
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: begin
        if (mreg_q == '0) begin
          state_d   = S_FIX;
          ld_expo_d = '0;
          zero_d    = 1'b1;
        end else if (mreg_q[MANT_W] && expo_val >= EXP_SAT) begin
          // Incrementing would reach or pass the reserved all-ones exponent.
          state_d   = S_FIX;
          ld_expo_d = EXP_MAX;
          mreg_d    = '0;
          ovf_d     = 1'b1;
        end else if (mreg_q[MANT_W]) begin
          state_d = S_SHR;
          mreg_d  = mreg_q >> 1;
        end else if (mreg_q[MANT_W-1]) begin
          state_d = S_DONE;
        end else if (expo_val == '0) begin
          state_d = S_DONE;
          unf_d   = 1'b1;
        end else if (expo_val == EXP_ONE) begin
          state_d   = S_FIX;
          ld_expo_d = '0;
          unf_d     = 1'b1;
        end else begin
          state_d = S_SHL;
          mreg_d  = mreg_q << 1;
        end
      end
      S_SHR:   state_d = S_DONE;
      S_SHL:   state_d = S_CHECK;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ldex_d = (state_d == S_LOAD) || (state_d == S_FIX);
    ince_d = (state_d == S_SHR);
    dece_d = (state_d == S_SHL);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mreg_q    <= '0;
      ld_expo_q <= '0;
      ldex_q    <= 1'b0;
      ince_q    <= 1'b0;
      dece_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mreg_q    <= mreg_d;
      ld_expo_q <= ld_expo_d;
      ldex_q    <= ldex_d;
      ince_q    <= ince_d;
      dece_q    <= dece_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign ldex      = ldex_q;
  assign ince      = ince_q;
  assign dece      = dece_q;
  assign ld_expo   = ld_expo_q;
  assign norm_mant = mreg_q[MANT_W-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_norm_ctrl.sv
// Bench for norm_ctrl: models the exponent register and scoreboards each normalization request.
module tb_norm_ctrl;
  localparam int MW = 24;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [MW:0]   sum_mant = '0;
  logic [EW-1:0] sum_expo = '0;
  logic [EW-1:0] expo_val = '0;
  logic          ldex, ince, dece, busy, done, zero, ovf, unf;
  logic [EW-1:0] ld_expo;
  logic [MW-1:0] norm_mant;

  norm_ctrl #(.MANT_W(MW), .EXP_W(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .sum_mant(sum_mant),
    .sum_expo(sum_expo), .expo_val(expo_val), .ldex(ldex), .ince(ince),
    .dece(dece), .ld_expo(ld_expo), .norm_mant(norm_mant), .busy(busy),
    .done(done), .zero(zero), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // Exponent register the controller drives.
  always @(posedge clk) begin
    if (reset)     expo_val <= '0;
    else if (ldex) expo_val <= ld_expo;
    else if (ince) expo_val <= expo_val + 8'd1;
    else if (dece) expo_val <= expo_val - 8'd1;
  end

  typedef struct {
    logic [MW:0]   mant;
    logic [EW-1:0] expo;
    logic [MW-1:0] norm;
    logic [EW-1:0] fexp;
    logic          z, o, u;
    int            lat, n_ince, n_dece, n_ldex;
    logic [EW-1:0] last_ld;
  } vec_t;

  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [MW:0] m, input logic [EW-1:0] e,
                              input logic [MW-1:0] nm, input logic [EW-1:0] fe,
                              input logic z, input logic o, input logic u,
                              input int lat, input int ni, input int nd, input int nl,
                              input logic [EW-1:0] ll);
    vec_t v;
    v.mant = m; v.expo = e; v.norm = nm; v.fexp = fe;
    v.z = z; v.o = o; v.u = u;
    v.lat = lat; v.n_ince = ni; v.n_dece = nd; v.n_ldex = nl; v.last_ld = ll;
    return v;
  endfunction

  // Drives one request; poke re-asserts start mid-operation, which must be ignored.
  task automatic run_op(input vec_t v, input string tag, input bit poke);
    int n, ni, nd, nl;
    logic [EW-1:0] ll;
    bit bad, got;
    vec_t e;
    ni = 0; nd = 0; nl = 0; ll = '0; bad = 0; got = 0;
    @(negedge clk);
    sum_mant = v.mant; sum_expo = v.expo; start = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n <= 200 && !got) begin
      if (poke && n == 2) begin start = 1'b1; sum_mant = '0; sum_expo = 8'd3; end
      if (poke && n == 3) start = 1'b0;
      if (ince) ni++;
      if (dece) nd++;
      if (ldex) begin nl++; ll = ld_expo; end
      if (32'(ince) + 32'(dece) + 32'(ldex) > 1) bad = 1;
      if (dece && (n % 2 == 0)) bad = 1;
      if (ince && expo_val >= 8'd254) bad = 1;
      if (dece && expo_val <= 8'd1) bad = 1;
      if (!busy) bad = 1;
      if (done) got = 1;
      else begin @(negedge clk); n++; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done after %0d cycles, required %0d", tag, n, v.lat);
      start = 1'b0;
    end else if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_scoreboard: done with empty queue, required one entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, 32'(n), 32'(e.lat));
      chk({tag, "_norm_mant"}, 32'(norm_mant), 32'(e.norm));
      chk({tag, "_expo_val"}, 32'(expo_val), 32'(e.fexp));
      chk({tag, "_flags_zou"}, 32'({zero, ovf, unf}), 32'({e.z, e.o, e.u}));
      chk({tag, "_ince_count"}, 32'(ni), 32'(e.n_ince));
      chk({tag, "_dece_count"}, 32'(nd), 32'(e.n_dece));
      chk({tag, "_ldex_count"}, 32'(nl), 32'(e.n_ldex));
      chk({tag, "_last_ld_expo"}, 32'(ll), 32'(e.last_ld));
      chk({tag, "_cmd_rules"}, 32'(bad), 32'd0);
    end
    sb.delete();
    @(negedge clk);
    chk({tag, "_done_busy_after"}, 32'({done, busy}), 32'd0);
    chk({tag, "_result_held"}, 32'({norm_mant, zero, ovf, unf}),
        32'({v.norm, v.z, v.o, v.u}));
  endtask

  vec_t tv[9];

  initial begin
    int  n;
    bit  bad;
    tv[0] = mk(25'h0800000, 8'd127, 24'h800000, 8'd127, 0, 0, 0, 3,  0, 0,  1, 8'd127);
    tv[1] = mk(25'h1000001, 8'd127, 24'h800000, 8'd128, 0, 0, 0, 4,  1, 0,  1, 8'd127);
    tv[2] = mk(25'h0000100, 8'd100, 24'h800000, 8'd85,  0, 0, 0, 33, 0, 15, 1, 8'd100);
    tv[3] = mk(25'h0000001, 8'd5,   24'h000010, 8'd0,   0, 0, 1, 12, 0, 4,  2, 8'd0);
    tv[4] = mk(25'h1000000, 8'd254, 24'h000000, 8'd255, 0, 1, 0, 4,  0, 0,  2, 8'd255);
    tv[5] = mk(25'h0000000, 8'd90,  24'h000000, 8'd0,   1, 0, 0, 4,  0, 0,  2, 8'd0);
    tv[6] = mk(25'h0000400, 8'd0,   24'h000400, 8'd0,   0, 0, 1, 3,  0, 0,  1, 8'd0);
    tv[7] = mk(25'h1800000, 8'd253, 24'hC00000, 8'd254, 0, 0, 0, 4,  1, 0,  1, 8'd253);
    tv[8] = mk(25'h0400000, 8'd1,   24'h400000, 8'd0,   0, 0, 1, 4,  0, 0,  2, 8'd0);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_cmds", 32'({ldex, ince, dece}), 32'd0);
    chk("reset_status", 32'({busy, done, zero, ovf, unf}), 32'd0);
    chk("reset_ld_expo", 32'(ld_expo), 32'd0);
    chk("reset_norm_mant", 32'(norm_mant), 32'd0);

    for (int i = 0; i < 9; i++)
      run_op(tv[i], $sformatf("vec%0d", i + 1), 1'b0);
    run_op(tv[2], "busy_start", 1'b1);

    // Abort a long left-shift run with reset in cycle 10.
    @(negedge clk);
    sum_mant = 25'h0000100; sum_expo = 8'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_expo_val", 32'(expo_val), 32'd0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (ldex || ince || dece || done || busy) bad = 1;
      @(negedge clk);
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    chk("abort_expo_held", 32'(expo_val), 32'd0);
    run_op(tv[0], "restart", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
